// File: rtl/cluster_vector_loader.sv
// Cluster vector loader: assembles a 32-bit word stream into the evaluator input vector,
// holds it for a settle window, then streams the captured evaluator outputs back.
module cluster_vector_loader #(
  parameter int unsigned IN_W       = 1894,
  parameter int unsigned OUT_W      = 64,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic [IN_W-1:0]  vec_o,
  input  logic [OUT_W-1:0] res_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic             err_len
);

  localparam int unsigned NW_IN   = (IN_W + 31) / 32;
  localparam int unsigned NW_OUT  = (OUT_W + 31) / 32;
  localparam int unsigned MAX_A   = (NW_IN > SETTLE_CYC) ? NW_IN : SETTLE_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > NW_OUT) ? MAX_A : NW_OUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SIDX_W  = (NW_IN > 1) ? $clog2(NW_IN) : 1;
  localparam int unsigned OIDX_W  = (NW_OUT > 1) ? $clog2(NW_OUT) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_SETTLE,
    ST_SEND
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [NW_IN-1:0][31:0]   r_shadow;
  logic [IN_W-1:0]          r_vec;
  logic [NW_OUT-1:0][31:0]  r_result;
  logic                     r_m_valid;
  logic [31:0]              r_m_data;
  logic                     r_m_last;
  logic                     r_err_len;

  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_m_valid_nxt;
  logic [31:0]              w_m_data_nxt;
  logic                     w_m_last_nxt;
  logic                     w_err_nxt;
  logic                     w_shadow_we;
  logic                     w_commit;
  logic                     w_sample;
  logic [NW_IN-1:0][31:0]   w_full;
  logic [NW_OUT-1:0][31:0]  w_res_words;

  assign s_ready     = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign vec_o       = r_vec;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign err_len     = r_err_len;
  assign w_res_words = (NW_OUT*32)'(res_i);

  // Commit image: shadow with the final word taken straight from the bus
  always_comb begin
    w_full          = r_shadow;
    w_full[NW_IN-1] = s_data;
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cnt_inc     = r_cnt + CNT_W'(1);
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    w_m_last_nxt  = r_m_last;
    w_err_nxt     = 1'b0;
    w_shadow_we   = 1'b0;
    w_commit      = 1'b0;
    w_sample      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (s_valid) begin
          w_shadow_we = 1'b1;
          if (r_cnt == CNT_W'(NW_IN - 1)) begin
            w_cnt_nxt = '0;
            if (s_last) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_SETTLE;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end else if (s_last) begin
            w_err_nxt = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_DRAIN: begin
        if (s_valid && s_last) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
          w_sample      = 1'b1;
          w_cnt_nxt     = '0;
          w_m_valid_nxt = 1'b1;
          w_m_data_nxt  = w_res_words[0];
          w_m_last_nxt  = (NW_OUT == 1);
          w_state_nxt   = ST_SEND;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_SEND: begin
        if (r_m_valid && m_ready) begin
          if (r_cnt == CNT_W'(NW_OUT - 1)) begin
            w_m_valid_nxt = 1'b0;
            w_m_data_nxt  = '0;
            w_m_last_nxt  = 1'b0;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_LOAD;
          end else begin
            w_cnt_nxt    = w_cnt_inc;
            w_m_data_nxt = r_result[OIDX_W'(w_cnt_inc)];
            w_m_last_nxt = (w_cnt_inc == CNT_W'(NW_OUT - 1));
          end
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Control state and outbound stream registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_last  <= w_m_last_nxt;
      r_err_len <= w_err_nxt;
    end
  end

  // Datapath: shadow assembly, vector commit, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_vec    <= '0;
      r_result <= '0;
    end else begin
      if (w_shadow_we) r_shadow[SIDX_W'(r_cnt)] <= s_data;
      if (w_commit)    r_vec <= IN_W'(w_full);
      if (w_sample)    r_result <= w_res_words;
    end
  end

endmodule
